fp_mul_pipe: RTL and testbench

//  Parametrised, fully pipelined IEEE-754-style floating-point multiplier; successor to the single-issue fp16 multiplier.

---
 rtl/fp_mul_pipe.sv | 191 +++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier (fp16 default, bf16/fp32 via EXP_W/MAN_W), one op per cycle.
// Latency: 3 cycles from accept to out_valid (unpack/classify, mantissa product, normalise/round/pack).
// Backpressure: a held result (out_valid & ~out_ready) freezes every stage; in_ready = ~stall.
//
// Ports:
//   clk, RST (async, active-high)
//   in_valid/in_ready, a, b, in_tag : operand pair and its sideband tag
//   out_valid/out_ready, result, out_tag : product and the tag of that operation
//   flags {invalid,overflow,underflow,inexact} : only when FP_MUL_FLAGS_EN is defined
// Optional feature macro: FP_MUL_FLAGS_EN (undefined -> no flags port, no flag logic).
// Subnormal inputs are read as signed zero; results that would be subnormal flush to signed zero.
module fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [TAG_W-1:0]       out_tag
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);

  localparam int PW = 2*MAN_W + 2;  // full mantissa product width

  localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [MAN_W-1:0] QNAN_FRAC = {1'b1, {(MAN_W-1){1'b0}}};
  // Exponent arithmetic is EXP_W+2 bits, two's complement, so sums below zero stay visible.
  localparam logic [EXP_W+1:0] BIAS      = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W+1:0] EXP_MAX   = {2'b00, {EXP_W{1'b1}}};

  // ---------------------------------------------------------------- stage 1 decode
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

  assign ea = a[EXP_W+MAN_W-1:MAN_W];
  assign eb = b[EXP_W+MAN_W-1:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  assign a_nan  = (ea == EXP_ONES) &  (|fa);
  assign a_inf  = (ea == EXP_ONES) & ~(|fa);
  assign a_zero = (ea == '0);          // subnormals collapse to zero here
  assign b_nan  = (eb == EXP_ONES) &  (|fb);
  assign b_inf  = (eb == EXP_ONES) & ~(|fb);
  assign b_zero = (eb == '0);

  logic stall, advance;
  assign stall     = out_valid & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = advance;

  // Stage registers
  logic                 s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [EXP_W+1:0]     s1_esum;
  logic [MAN_W:0]       s1_ma, s1_mb;
  logic [TAG_W-1:0]     s1_tag;

  logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
  logic [EXP_W+1:0]     s2_esum;
  logic [PW-1:0]        s2_prod;
  logic [TAG_W-1:0]     s2_tag;

  logic                 s3_valid;

  // ---------------------------------------------------------------- stage 3 combinational
  logic             norm, guard_bit, sticky, round_up, rcarry, ovf, unf;
  logic [MAN_W-1:0] frac;
  logic [MAN_W:0]   frac_r;
  logic [EXP_W+1:0] e_fin;
  logic [EXP_W+MAN_W:0] res_d;

  // A product >= 2.0 (MSB set) takes its fraction one bit higher and bumps the exponent.
  assign norm      = s2_prod[PW-1];
  assign frac      = norm ? s2_prod[2*MAN_W:MAN_W+1] : s2_prod[2*MAN_W-1:MAN_W];
  assign guard_bit = norm ? s2_prod[MAN_W]           : s2_prod[MAN_W-1];
  assign sticky    = norm ? (|s2_prod[MAN_W-1:0])    : (|s2_prod[MAN_W-2:0]);

  // Round to nearest, ties to even.
  assign round_up  = guard_bit & (sticky | frac[0]);
  assign frac_r    = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
  // An all-ones fraction rounding up wraps to zero and carries into the exponent.
  assign rcarry    = frac_r[MAN_W];

  assign e_fin = s2_esum + {{(EXP_W+1){1'b0}}, norm} + {{(EXP_W+1){1'b0}}, rcarry};
  assign unf   = e_fin[EXP_W+1] | (e_fin == '0);
  assign ovf   = ~e_fin[EXP_W+1] & (e_fin >= EXP_MAX);

  always_comb begin
    res_d = '0;
    if (s2_nan)
      res_d = {1'b0, EXP_ONES, QNAN_FRAC};
    else if (s2_inf)
      res_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (s2_zero)
      res_d = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
    else if (ovf)
      res_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (unf)
      res_d = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
    else
      res_d = {s2_sign, e_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
  end

`ifdef FP_MUL_FLAGS_EN
  logic [3:0] flags_d;
  always_comb begin
    flags_d = 4'b0000;
    if (s2_nan)
      flags_d = 4'b1000;
    else if (s2_inf | s2_zero)
      flags_d = 4'b0000;
    else if (ovf)
      flags_d = 4'b0101;
    else if (unf)
      flags_d = 4'b0011;
    else
      flags_d = {3'b000, guard_bit | sticky};
  end
`endif

  // ---------------------------------------------------------------- pipeline registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_esum  <= '0;
      s1_ma    <= '0;
      s1_mb    <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
      s2_zero  <= 1'b0;
      s2_esum  <= '0;
      s2_prod  <= '0;
      s2_tag   <= '0;
      s3_valid <= 1'b0;
      result   <= '0;
      out_tag  <= '0;
`ifdef FP_MUL_FLAGS_EN
      flags    <= 4'b0000;
`endif
    end else if (advance) begin
      // S1: classify and form the unbiased-sum exponent
      s1_valid <= in_valid;
      s1_sign  <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
      s1_nan   <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s1_inf   <= a_inf | b_inf;
      s1_zero  <= a_zero | b_zero;
      s1_esum  <= {2'b00, ea} + {2'b00, eb} - BIAS;
      s1_ma    <= {1'b1, fa};
      s1_mb    <= {1'b1, fb};
      s1_tag   <= in_tag;
      // S2: mantissa product; special classes ride along (NaN outranks inf outranks zero in S3)
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_zero  <= s1_zero;
      s2_esum  <= s1_esum;
      s2_prod  <= {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};
      s2_tag   <= s1_tag;
      // S3: rounded, packed result
      s3_valid <= s2_valid;
      result   <= res_d;
      out_tag  <= s2_tag;
`ifdef FP_MUL_FLAGS_EN
      flags    <= flags_d;
`endif
    end
  end

  assign out_valid = s3_valid;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: fp16 instance plus a bf16 instance, checked against a real-arithmetic model.
// Latency: accept edge plus two further edges before out_valid is seen.
// Backpressure: random out_ready drops exercise stalls; flags are checked when FP_MUL_FLAGS_EN is defined.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  // fp16 instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic [3:0]  in_tag, out_tag;
  // bf16 instance
  logic        bin_valid, bin_ready, bout_valid, bout_ready;
  logic [15:0] ba, bb, bresult;
  logic [3:0]  bin_tag, bout_tag;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  flags, bflags;
`endif

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut (
    .clk(clk), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag)
`ifdef FP_MUL_FLAGS_EN
    , .flags(flags)
`endif
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) dut_bf16 (
    .clk(clk), .RST(RST),
    .in_valid(bin_valid), .in_ready(bin_ready), .a(ba), .b(bb), .in_tag(bin_tag),
    .out_valid(bout_valid), .out_ready(bout_ready), .result(bresult), .out_tag(bout_tag)
`ifdef FP_MUL_FLAGS_EN
    , .flags(bflags)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Directed fp16 vectors: a, b, expected result, expected {invalid,overflow,underflow,inexact}
  localparam int NV = 17;
  logic [15:0] vec_a [NV] = '{16'h4000, 16'h3E00, 16'h3C01, 16'h7C00, 16'h7BFF, 16'h0400,
                              16'hC000, 16'h8000, 16'h0001, 16'hFC00, 16'h7E01, 16'h3C10,
                              16'h3C01, 16'h3E00, 16'h0400, 16'h0400, 16'h7BFF};
  logic [15:0] vec_b [NV] = '{16'h4200, 16'h3E00, 16'h3C01, 16'h0000, 16'h4000, 16'h0400,
                              16'h4200, 16'h7C00, 16'h4000, 16'h4000, 16'h3C00, 16'h3C20,
                              16'h3E00, 16'h3D55, 16'h3C00, 16'h3BFF, 16'h3C00};
  logic [15:0] vec_r [NV] = '{16'h4600, 16'h4080, 16'h3C02, 16'h7E00, 16'h7C00, 16'h0000,
                              16'hC600, 16'h7E00, 16'h0000, 16'hFC00, 16'h7E00, 16'h3C30,
                              16'h3E02, 16'h4000, 16'h0400, 16'h0000, 16'h7BFF};
  logic [3:0]  vec_f [NV] = '{4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0101, 4'b0011,
                              4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0001,
                              4'b0001, 4'b0001, 4'b0000, 4'b0011, 4'b0000};

  // ---------------------------------------------------------------- reference model
  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else        repeat (-k) r = r / 2.0;
    return r;
  endfunction

  // Returns {flags[3:0], result[31:0]} for a format with ew exponent / mw fraction bits.
  function automatic logic [35:0] ref_mul(input logic [31:0] xa, input logic [31:0] xb,
                                          input int ew, input int mw);
    int  bias, emax, ea, eb, fa, fb, e, f, be;
    logic [31:0] sgn, inf_w, nan_w, res;
    logic na, nb, ia, ib, za, zb;
    real va, vb, m, sc, r;
    logic inx;
    bias  = (1 << (ew - 1)) - 1;
    emax  = (1 << ew) - 1;
    ea    = int'((xa >> mw) & 32'(emax));
    eb    = int'((xb >> mw) & 32'(emax));
    fa    = int'(xa & 32'((1 << mw) - 1));
    fb    = int'(xb & 32'((1 << mw) - 1));
    sgn   = 32'(xa[ew+mw] ^ xb[ew+mw]) << (ew + mw);
    inf_w = 32'(emax) << mw;
    nan_w = inf_w | (32'd1 << (mw - 1));
    na = (ea == emax) && (fa != 0);  ia = (ea == emax) && (fa == 0);  za = (ea == 0);
    nb = (eb == emax) && (fb != 0);  ib = (eb == emax) && (fb == 0);  zb = (eb == 0);
    if (na || nb || (ia && zb) || (ib && za)) return {4'b1000, nan_w};
    if (ia || ib) return {4'b0000, sgn | inf_w};
    if (za || zb) return {4'b0000, sgn};
    va = (1.0 + real'(fa) / pow2(mw)) * pow2(ea - bias);
    vb = (1.0 + real'(fb) / pow2(mw)) * pow2(eb - bias);
    m  = va * vb;
    e  = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    sc  = m * pow2(mw);
    f   = $rtoi(sc);
    r   = sc - real'(f);
    inx = (r != 0.0);
    if (r > 0.5 || (r == 0.5 && (f % 2) == 1)) f++;
    if (f == (1 << (mw + 1))) begin f = f / 2; e++; end
    be = e + bias;
    if (be >= emax) return {4'b0101, sgn | inf_w};
    if (be <= 0)    return {4'b0011, sgn};
    res = sgn | (32'(be) << mw) | 32'(f - (1 << mw));
    return {3'b000, inx, res};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb, input logic [3:0] t,
                       output logic [15:0] r, output logic [3:0] rt, output logic [3:0] rf,
                       output int lat);
    @(negedge clk);
    a = xa; b = xb; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    r = result; rt = out_tag;
`ifdef FP_MUL_FLAGS_EN
    rf = flags;
`else
    rf = 4'b0000;
`endif
  endtask

  task automatic do_op_bf(input logic [15:0] xa, input logic [15:0] xb, input logic [3:0] t,
                          output logic [15:0] r, output logic [3:0] rt, output logic [3:0] rf,
                          output int lat);
    @(negedge clk);
    ba = xa; bb = xb; bin_tag = t; bin_valid = 1'b1;
    @(posedge clk); #1;
    bin_valid = 1'b0;
    lat = 0;
    while (!bout_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    r = bresult; rt = bout_tag;
`ifdef FP_MUL_FLAGS_EN
    rf = bflags;
`else
    rf = 4'b0000;
`endif
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h want=0000", result); end
    n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    n_checks++; if (bout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bf16_out_valid got=%b want=0", bout_valid); end
`ifdef FP_MUL_FLAGS_EN
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b want=0000", flags); end
`endif
    @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic test_vectors();
    logic [15:0] r; logic [3:0] rt, rf; int lat;
    for (int i = 0; i < NV; i++) begin
      do_op(vec_a[i], vec_b[i], 4'(i), r, rt, rf, lat);
      n_checks++; if (r !== vec_r[i]) begin n_fail++; $display("FAIL vec%0d_result a=%h b=%h got=%h want=%h", i, vec_a[i], vec_b[i], r, vec_r[i]); end
      n_checks++; if (rt !== 4'(i)) begin n_fail++; $display("FAIL vec%0d_tag got=%h want=%h", i, rt, 4'(i)); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL vec%0d_latency got=%0d extra edges want=2", i, lat); end
`ifdef FP_MUL_FLAGS_EN
      n_checks++; if (rf !== vec_f[i]) begin n_fail++; $display("FAIL vec%0d_flags got=%b want=%b", i, rf, vec_f[i]); end
`endif
    end
  endtask

  task automatic test_bf16();
    logic [15:0] r, xa, xb; logic [3:0] rt, rf; int lat;
    logic [35:0] m;
    logic [15:0] da [3] = '{16'h4000, 16'h3FC0, 16'h3F81};
    logic [15:0] db [3] = '{16'h4040, 16'h3FC0, 16'h3F81};
    logic [15:0] dr [3] = '{16'h40C0, 16'h4010, 16'h3F82};
    for (int i = 0; i < 3; i++) begin
      do_op_bf(da[i], db[i], 4'(i + 5), r, rt, rf, lat);
      n_checks++; if (r !== dr[i]) begin n_fail++; $display("FAIL bf16_vec%0d_result got=%h want=%h", i, r, dr[i]); end
      n_checks++; if (rt !== 4'(i + 5)) begin n_fail++; $display("FAIL bf16_vec%0d_tag got=%h want=%h", i, rt, 4'(i + 5)); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bf16_vec%0d_latency got=%0d want=2", i, lat); end
    end
    for (int i = 0; i < 12; i++) begin
      xa = 16'($urandom); xb = 16'($urandom);
      m  = ref_mul({16'h0, xa}, {16'h0, xb}, 8, 7);
      do_op_bf(xa, xb, 4'(i), r, rt, rf, lat);
      n_checks++; if (r !== m[15:0]) begin n_fail++; $display("FAIL bf16_rand%0d a=%h b=%h got=%h want=%h", i, xa, xb, r, m[15:0]); end
`ifdef FP_MUL_FLAGS_EN
      n_checks++; if (rf !== m[35:32]) begin n_fail++; $display("FAIL bf16_rand%0d_flags got=%b want=%b", i, rf, m[35:32]); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    logic [15:0] qa [N]; logic [15:0] qb [N];
    logic [35:0] exp_q [$];
    logic [3:0]  tag_q [$];
    logic [35:0] m;
    int sent, recv, cyc;
    for (int i = 0; i < N; i++) begin qa[i] = 16'($urandom); qb[i] = 16'($urandom); end
    sent = 0; recv = 0; cyc = 0;
    while (recv < N && cyc < 200) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (sent < N) begin in_valid = 1'b1; a = qa[sent]; b = qb[sent]; in_tag = 4'(sent); end
      else in_valid = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, in_ready); end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul({16'h0, qa[sent]}, {16'h0, qb[sent]}, 5, 10));
        tag_q.push_back(4'(sent));
        sent++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL b2b_spurious_output cyc=%0d result=%h want=no output", cyc, result);
        end else begin
          m = exp_q.pop_front();
          n_checks++; if (result !== m[15:0]) begin n_fail++; $display("FAIL b2b_result%0d got=%h want=%h", recv, result, m[15:0]); end
          n_checks++; if (out_tag !== tag_q.pop_front()) begin n_fail++; $display("FAIL b2b_tag%0d got=%h want=%h", recv, out_tag, 4'(recv)); end
`ifdef FP_MUL_FLAGS_EN
          n_checks++; if (flags !== m[35:32]) begin n_fail++; $display("FAIL b2b_flags%0d got=%b want=%b", recv, flags, m[35:32]); end
`endif
          recv++;
        end
      end
      @(posedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++; if (recv !== N) begin n_fail++; $display("FAIL b2b_count got=%0d want=%0d", recv, N); end
    n_checks++; if (cyc !== N + 3) begin n_fail++; $display("FAIL b2b_throughput cycles got=%0d want=%0d", cyc, N + 3); end
  endtask

  task automatic test_stream();
    localparam int N = 10;
    logic [15:0] qa [N]; logic [15:0] qb [N];
    logic [35:0] exp_q [$];
    int tag_q [$];
    int sent, recv, cyc, spurious;
    for (int i = 0; i < N; i++) begin qa[i] = 16'($urandom); qb[i] = 16'($urandom); end
    sent = 0; recv = 0; cyc = 0; spurious = 0;
    while ((recv < N || cyc < N + 8) && cyc < 300) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) >= 35);
      if (sent < N) begin in_valid = 1'b1; a = qa[sent]; b = qb[sent]; in_tag = 4'(sent); end
      else in_valid = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++; $display("FAIL stream_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul({16'h0, qa[sent]}, {16'h0, qb[sent]}, 5, 10));
        tag_q.push_back(sent);
        sent++;
      end
      // While held, the output must keep showing the queue head (stable result and tag).
      if (out_valid) begin
        if (exp_q.size() == 0) spurious++;
        else begin
          n_checks++; if (result !== exp_q[0][15:0]) begin n_fail++; $display("FAIL stream_result item=%0d cyc=%0d got=%h want=%h", tag_q[0], cyc, result, exp_q[0][15:0]); end
          n_checks++; if (out_tag !== 4'(tag_q[0])) begin n_fail++; $display("FAIL stream_tag cyc=%0d got=%h want=%h", cyc, out_tag, 4'(tag_q[0])); end
          if (out_ready) begin void'(exp_q.pop_front()); void'(tag_q.pop_front()); recv++; end
        end
      end
      @(posedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (recv !== N) begin n_fail++; $display("FAIL stream_count got=%0d want=%0d", recv, N); end
    n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL stream_spurious got=%0d extra outputs want=0", spurious); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; logic [3:0] rt, rf; int lat, seen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; a = 16'h4000; b = 16'h4000; in_tag = 4'(12 + i);
    end
    @(posedge clk);
    #3;
    RST = 1'b1; in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL midrst_result got=%h want=0000", result); end
    @(negedge clk);
    RST = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_stale_output got=%0d want=0", seen); end
    do_op(16'h4000, 16'h4200, 4'h9, r, rt, rf, lat);
    n_checks++; if (r !== 16'h4600) begin n_fail++; $display("FAIL midrst_after_result got=%h want=4600", r); end
    n_checks++; if (rt !== 4'h9) begin n_fail++; $display("FAIL midrst_after_tag got=%h want=9", rt); end
  endtask

  initial begin
    RST = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
    bin_valid = 1'b0; ba = '0; bb = '0; bin_tag = '0; bout_ready = 1'b1;
    test_reset();
    test_vectors();
    test_bf16();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
